axil_master_bridge: RTL and testbench
=====================================

Name: axil_master_bridge

Overview:
- Converts a simple single-outstanding command/response interface into AXI4-Lite master transactions.
- Sits directly upstream of the team's AXI4-Lite slave memory and drives its five channels (AW, W, B, AR, R).
- One transaction in flight at a time, either read or write.
- Captures BRESP/RRESP and RDATA and returns them to the requester.

Parameters:
- WIDTH, 32, address and data width; byte-strobe width is WIDTH/8.
- TIMEOUT_CYCLES, 255, watchdog limit in ACLK cycles; used only when AXIL_MASTER_TIMEOUT_EN is defined.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESETn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high while the bridge is IDLE.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  WIDTH  byte address.
- cmd_wdata  in  WIDTH  write data.
- cmd_wstrb  in  WIDTH/8  write byte strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  requester accepts the response.
- rsp_write  out  1  echo of cmd_write for this transaction.
- rsp_rdata  out  WIDTH  captured RDATA; 0 for writes.
- rsp_resp  out  2  captured BRESP/RRESP.
- AWADDR/AWVALID  out  WIDTH/1; AWREADY  in  1.
- WDATA/WSTRB/WVALID  out  WIDTH/WIDTH/8/1; WREADY  in  1.
- BRESP/BVALID  in  2/1; BREADY  out  1.
- ARADDR/ARVALID  out  WIDTH/1; ARREADY  in  1.
- RDATA/RRESP/RVALID  in  WIDTH/2/1; RREADY  out  1.

Behaviour:
- Reset and clock: ACLK is the clock; ARESETn is the reset, asynchronous, active-low.
- Reset values: all outputs registered; all VALID/READY outputs 0, rsp_* 0, AWADDR/ARADDR/WDATA/WSTRB 0, state IDLE.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid at edge N: latch addr/wdata/wstrb/write.
  - Go to WR_REQ (write) or RD_REQ (read).
  - AWVALID+WVALID (write) or ARVALID (read) are high from cycle N+1.
- WR_REQ:
  - AW and W tracked independently with flags aw_done/w_done.
  - AWVALID drops the cycle after an AWREADY&AWVALID edge; WVALID likewise on WREADY.
  - Either order or simultaneous completion allowed.
  - Move to WR_RESP when both flags are set; BREADY=1 on entry.
- WR_RESP:
  - BREADY held high until BVALID.
  - On BVALID&BREADY: capture BRESP, rsp_rdata=0, BREADY→0, go to DONE.
  - BVALID arriving before both AW/W handshakes complete is ignored (BREADY low).
- RD_REQ: ARVALID held until ARREADY; then ARVALID→0, RREADY→1, go to RD_RESP.
- RD_RESP: on RVALID&RREADY, capture RDATA and RRESP, RREADY→0, go to DONE.
- DONE: rsp_valid=1, held with stable data until rsp_ready; then rsp_valid→0 and return to IDLE. Next cmd is accepted no earlier than the following edge.
- AXI rules:
  - A VALID, once asserted, is never deasserted before its READY.
  - Address/data/strobe stay stable while VALID.
  - VALID never depends combinationally on READY.
- Minimum latency with zero-wait slave:
  - write: cmd accept → rsp_valid in 4 cycles (AW/W handshake, B handshake, DONE).
  - read: 4 cycles.
- cmd_valid while not IDLE: ignored (cmd_ready=0).
- Reset mid-transaction: all VALID/READY outputs drop immediately (async); the transaction is discarded and no response is produced.
- wstrb=0 write: still issued; response returned normally.

Optional Feature:
- Macro: AXIL_MASTER_TIMEOUT_EN.
- Defined:
  - A WIDTH-independent 16-bit counter clears on each state entry and increments in WR_REQ/WR_RESP/RD_REQ/RD_RESP.
  - On reaching TIMEOUT_CYCLES: all VALID/READY outputs drop, rsp_resp=2'b10 (SLVERR), rsp_rdata=0, go to DONE.
  - Late slave handshakes after a timeout are ignored.
- Undefined: no counter; the bridge waits indefinitely.

Decomposition:
- Package axil_pkg holds:
  - response codes OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11;
  - the FSM state enum;
  - the default TIMEOUT_CYCLES constant.
- Sub-module axil_timeout_cnt (counter + expire flag) is natural and is instantiated only under the macro.
- The rest stays flat.

Test Plan:
- Write zero-wait: cmd_write=1, addr=0x0, wdata=0xA1B2C3D4, wstrb=4'hF → one AW/W handshake with those values; rsp_valid after 4 cycles; rsp_resp=00.
- Read back: addr=0x0 → ARADDR=0x0; rsp_rdata=0xA1B2C3D4, rsp_resp=00.
- Skewed handshakes: WREADY 3 cycles before AWREADY → WVALID drops after its handshake, AWVALID holds until AWREADY; exactly one B handshake.
- Backpressure: slave holds RVALID with RRESP=10; rsp_ready low for 5 cycles → rsp_valid and rsp_rdata stay stable; no new cmd_ready until released.
- Reset mid-write: ARESETn low while AWVALID=1 → AWVALID/WVALID=0 immediately; no rsp_valid after reset release; next read completes normally.
- With AXIL_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=8: slave never asserts ARREADY → ARVALID drops; rsp_valid with rsp_resp=10 at cycle 9 after accept.

Source files
------------

// File: rtl/axil_pkg.sv
// axil_pkg: AXI4-Lite response codes, bridge FSM states and default watchdog limit.
package axil_pkg;
  localparam logic [1:0] OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11;
  localparam int DEF_TIMEOUT_CYCLES = 255;
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_e;
endpackage

// File: rtl/axil_timeout_cnt.sv
// axil_timeout_cnt: per-state watchdog; expires on the LIMIT-th cycle spent in one waiting state.
module axil_timeout_cnt import axil_pkg::*; #(
  parameter int LIMIT = DEF_TIMEOUT_CYCLES
) (
  input  logic   ACLK,
  input  logic   ARESETn,
  input  state_e state,
  output logic   expired
);
  state_e st_q;
  logic [15:0] cnt, cur;
  logic en;
  assign en = state inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP};
  // a state differing from last cycle's is a fresh entry, so its count restarts at zero
  assign cur = (state != st_q) ? 16'd0 : cnt;
  assign expired = en && cur == 16'(LIMIT - 1);
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      st_q <= IDLE;
      cnt <= '0;
    end else begin
      st_q <= state;
      cnt <= en ? cur + 16'd1 : 16'd0;
    end
endmodule

// File: rtl/axil_master_bridge.sv
// axil_master_bridge: single-outstanding command/response to AXI4-Lite master bridge.
// Define AXIL_MASTER_TIMEOUT_EN to add a per-state watchdog that ends stuck transfers with SLVERR.
module axil_master_bridge import axil_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic               ACLK,
  input  logic               ARESETn,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [WIDTH-1:0]   cmd_addr,
  input  logic [WIDTH-1:0]   cmd_wdata,
  input  logic [WIDTH/8-1:0] cmd_wstrb,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_write,
  output logic [WIDTH-1:0]   rsp_rdata,
  output logic [1:0]         rsp_resp,
  output logic [WIDTH-1:0]   AWADDR,
  output logic               AWVALID,
  input  logic               AWREADY,
  output logic [WIDTH-1:0]   WDATA,
  output logic [WIDTH/8-1:0] WSTRB,
  output logic               WVALID,
  input  logic               WREADY,
  input  logic [1:0]         BRESP,
  input  logic               BVALID,
  output logic               BREADY,
  output logic [WIDTH-1:0]   ARADDR,
  output logic               ARVALID,
  input  logic               ARREADY,
  input  logic [WIDTH-1:0]   RDATA,
  input  logic [1:0]         RRESP,
  input  logic               RVALID,
  output logic               RREADY
);
  state_e state;
  logic tmo, aw_done, w_done;
  assign aw_done = !AWVALID || AWREADY;
  assign w_done = !WVALID || WREADY;
`ifdef AXIL_MASTER_TIMEOUT_EN
  axil_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .ACLK(ACLK), .ARESETn(ARESETn), .state(state), .expired(tmo)
  );
`else
  assign tmo = TIMEOUT_CYCLES < 0;
`endif
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      state <= IDLE;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp <= OKAY;
      AWADDR <= '0;
      ARADDR <= '0;
      WDATA <= '0;
      WSTRB <= '0;
      AWVALID <= 1'b0;
      WVALID <= 1'b0;
      BREADY <= 1'b0;
      ARVALID <= 1'b0;
      RREADY <= 1'b0;
    end else if (tmo) begin
      AWVALID <= 1'b0;
      WVALID <= 1'b0;
      BREADY <= 1'b0;
      ARVALID <= 1'b0;
      RREADY <= 1'b0;
      rsp_resp <= SLVERR;
      rsp_rdata <= '0;
      rsp_valid <= 1'b1;
      state <= DONE;
    end else begin
      case (state)
        IDLE:
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            rsp_write <= cmd_write;
            AWADDR <= cmd_addr;
            ARADDR <= cmd_addr;
            WDATA <= cmd_wdata;
            WSTRB <= cmd_wstrb;
            AWVALID <= cmd_write;
            WVALID <= cmd_write;
            ARVALID <= !cmd_write;
            state <= cmd_write ? WR_REQ : RD_REQ;
          end else cmd_ready <= 1'b1;
        WR_REQ: begin
          if (AWREADY) AWVALID <= 1'b0;
          if (WREADY) WVALID <= 1'b0;
          if (aw_done && w_done) begin
            BREADY <= 1'b1;
            state <= WR_RESP;
          end
        end
        WR_RESP:
          if (BVALID) begin
            rsp_resp <= BRESP;
            rsp_rdata <= '0;
            BREADY <= 1'b0;
            rsp_valid <= 1'b1;
            state <= DONE;
          end
        RD_REQ:
          if (ARREADY) begin
            ARVALID <= 1'b0;
            RREADY <= 1'b1;
            state <= RD_RESP;
          end
        RD_RESP:
          if (RVALID) begin
            rsp_rdata <= RDATA;
            rsp_resp <= RRESP;
            RREADY <= 1'b0;
            rsp_valid <= 1'b1;
            state <= DONE;
          end
        default:
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state <= IDLE;
          end
      endcase
    end
endmodule

// File: tb/tb_axil_master_bridge.sv
// tb_axil_master_bridge: randomized bench with a behavioural AXI4-Lite slave and a byte-map reference memory.
module tb_axil_master_bridge;
  logic ACLK = 1'b0, ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;
  logic cmd_valid = 0, cmd_ready, cmd_write = 0, rsp_valid, rsp_ready = 0, rsp_write;
  logic [31:0] cmd_addr = 0, cmd_wdata = 0, rsp_rdata;
  logic [3:0] cmd_wstrb = 0;
  logic [1:0] rsp_resp;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [3:0] WSTRB;
  logic AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY, ARVALID, ARREADY, RVALID, RREADY;
  logic [1:0] BRESP, RRESP;

  axil_master_bridge #(.WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY), .ARADDR(ARADDR), .ARVALID(ARVALID),
    .ARREADY(ARREADY), .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  int n_chk = 0, n_fail = 0, cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  int aw_lat = 0, w_lat = 0, ar_lat = 0;
  bit aw_blk = 0, w_blk = 0, ar_blk = 0, mon_en = 1;
  logic [1:0] b_resp_k = 0, r_resp_k = 0;
  bit aw_got, w_got, ar_got;
  int aw_cnt, w_cnt, ar_cnt;
  int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
  logic [31:0] last_awaddr, last_wdata, last_araddr, wv;
  logic [3:0] last_wstrb;
  logic [31:0] smem [int];

  always @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      AWREADY <= 0; WREADY <= 0; ARREADY <= 0; BVALID <= 0; RVALID <= 0;
      BRESP <= 0; RRESP <= 0; RDATA <= 0;
      aw_got <= 0; w_got <= 0; ar_got <= 0; aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
    end else begin
      aw_cnt <= (AWVALID && !AWREADY) ? aw_cnt + 1 : 0;
      w_cnt <= (WVALID && !WREADY) ? w_cnt + 1 : 0;
      ar_cnt <= (ARVALID && !ARREADY) ? ar_cnt + 1 : 0;
      AWREADY <= !aw_blk && (aw_lat == 0 || (AWVALID && !AWREADY && aw_cnt + 1 >= aw_lat));
      WREADY <= !w_blk && (w_lat == 0 || (WVALID && !WREADY && w_cnt + 1 >= w_lat));
      ARREADY <= !ar_blk && (ar_lat == 0 || (ARVALID && !ARREADY && ar_cnt + 1 >= ar_lat));
      if (AWVALID && AWREADY) begin aw_got <= 1; last_awaddr <= AWADDR; aw_hs <= aw_hs + 1; end
      if (WVALID && WREADY) begin w_got <= 1; last_wdata <= WDATA; last_wstrb <= WSTRB; w_hs <= w_hs + 1; end
      if (ARVALID && ARREADY) begin ar_got <= 1; last_araddr <= ARADDR; ar_hs <= ar_hs + 1; end
      if (aw_got && w_got && !BVALID) begin
        wv = smem.exists(int'(last_awaddr[31:2])) ? smem[int'(last_awaddr[31:2])] : 32'd0;
        for (int i = 0; i < 4; i++) if (last_wstrb[i]) wv[8*i +: 8] = last_wdata[8*i +: 8];
        smem[int'(last_awaddr[31:2])] = wv;
        BVALID <= 1; BRESP <= b_resp_k; aw_got <= 0; w_got <= 0;
      end
      if (BVALID && BREADY) begin BVALID <= 0; b_hs <= b_hs + 1; end
      if (ar_got && !RVALID) begin
        RVALID <= 1; RRESP <= r_resp_k; ar_got <= 0;
        RDATA <= smem.exists(int'(last_araddr[31:2])) ? smem[int'(last_araddr[31:2])] : 32'd0;
      end
      if (RVALID && RREADY) begin RVALID <= 0; r_hs <= r_hs + 1; end
    end
  end

  int proto_err = 0;
  logic aw_pv, aw_pr, w_pv, w_pr, ar_pv, ar_pr;
  logic [31:0] aw_pa, w_pd, ar_pa;
  logic [3:0] w_ps;
  always @(posedge ACLK) begin
    if (ARESETn && mon_en) begin
      if (aw_pv && !aw_pr && (!AWVALID || AWADDR !== aw_pa)) proto_err++;
      if (w_pv && !w_pr && (!WVALID || WDATA !== w_pd || WSTRB !== w_ps)) proto_err++;
      if (ar_pv && !ar_pr && (!ARVALID || ARADDR !== ar_pa)) proto_err++;
    end
    aw_pv <= AWVALID; aw_pr <= AWREADY; aw_pa <= AWADDR;
    w_pv <= WVALID; w_pr <= WREADY; w_pd <= WDATA; w_ps <= WSTRB;
    ar_pv <= ARVALID; ar_pr <= ARREADY; ar_pa <= ARADDR;
  end

  int skew_ok = 0, skew_bad = 0;
  always @(negedge ACLK)
    if (ARESETn && w_got && !aw_got) begin
      if (!WVALID && AWVALID) skew_ok++;
      else skew_bad++;
    end

  logic [7:0] ref_b [int];
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    logic [31:0] r;
    int base;
    base = int'({a[31:2], 2'b00});
    for (int i = 0; i < 4; i++) r[8*i +: 8] = ref_b.exists(base + i) ? ref_b[base + i] : 8'd0;
    return r;
  endfunction
  task automatic ref_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    for (int i = 0; i < 4; i++) if (s[i]) ref_b[int'({a[31:2], 2'b00}) + i] = d[8*i +: 8];
  endtask

  task automatic do_cmd(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int hold, output logic [31:0] rdata, output logic [1:0] resp, output bit rw,
                        output int lat, output int unstable, output bit post_idle, output bit ok);
    int c, n;
    ok = 0; unstable = 0; lat = 0; rdata = 0; resp = 0; rw = 0; post_idle = 0;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge ACLK); n++; end
    if (!cmd_ready) return;
    c = cyc;
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    @(negedge ACLK);
    cmd_valid = 0;
    n = 0;
    while (!rsp_valid && n < 200) begin @(negedge ACLK); n++; end
    if (!rsp_valid) return;
    lat = cyc - c; rdata = rsp_rdata; resp = rsp_resp; rw = rsp_write;
    repeat (hold) begin
      @(negedge ACLK);
      if (!rsp_valid || rsp_rdata !== rdata || rsp_resp !== resp || cmd_ready) unstable++;
    end
    rsp_ready = 1;
    @(negedge ACLK);
    rsp_ready = 0;
    post_idle = !rsp_valid && cmd_ready;
    ok = 1;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge ACLK);
    n_chk++;
    if ({cmd_ready, rsp_valid, AWVALID, WVALID, BREADY, ARVALID, RREADY} !== 7'b0) begin
      n_fail++; $display("FAIL reset_handshakes: got %b want 0", {cmd_ready, rsp_valid, AWVALID, WVALID, BREADY, ARVALID, RREADY});
    end
    n_chk++;
    if ({rsp_write, rsp_rdata, rsp_resp, AWADDR, ARADDR, WDATA, WSTRB} !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h want 0", {rsp_write, rsp_rdata, rsp_resp, AWADDR, ARADDR, WDATA, WSTRB});
    end
    ARESETn = 1;
    repeat (2) @(negedge ACLK);
    n_chk++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_write_zero_wait;
    logic [31:0] rd; logic [1:0] rs; bit rw, pi, ok; int lat, un, aw0, w0, b0;
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
    do_cmd(1, 32'h0, 32'hA1B2C3D4, 4'hF, 0, rd, rs, rw, lat, un, pi, ok);
    ref_wr(32'h0, 32'hA1B2C3D4, 4'hF);
    n_chk++;
    if (!ok) begin n_fail++; $display("FAIL wr0_done: got timeout want response"); end
    n_chk++;
    if (lat !== 4) begin n_fail++; $display("FAIL wr0_latency: got %0d want 4", lat); end
    n_chk++;
    if ({rs, rw, rd} !== {2'b00, 1'b1, 32'h0}) begin n_fail++; $display("FAIL wr0_rsp: got %h want %h", {rs, rw, rd}, {2'b00, 1'b1, 32'h0}); end
    n_chk++;
    if ({last_awaddr, last_wdata, last_wstrb} !== {32'h0, 32'hA1B2C3D4, 4'hF}) begin
      n_fail++; $display("FAIL wr0_payload: got %h want %h", {last_awaddr, last_wdata, last_wstrb}, {32'h0, 32'hA1B2C3D4, 4'hF});
    end
    n_chk++;
    if ({aw_hs - aw0, w_hs - w0, b_hs - b0} !== {32'd1, 32'd1, 32'd1}) begin
      n_fail++; $display("FAIL wr0_handshakes: got aw %0d w %0d b %0d want 1 each", aw_hs - aw0, w_hs - w0, b_hs - b0);
    end
  endtask

  task automatic test_read_back;
    logic [31:0] rd; logic [1:0] rs; bit rw, pi, ok; int lat, un;
    do_cmd(0, 32'h0, 32'h0, 4'h0, 0, rd, rs, rw, lat, un, pi, ok);
    n_chk++;
    if (!ok || lat !== 4) begin n_fail++; $display("FAIL rd0_latency: got %0d ok %0b want 4", lat, ok); end
    n_chk++;
    if ({rs, rw, rd} !== {2'b00, 1'b0, 32'hA1B2C3D4}) begin n_fail++; $display("FAIL rd0_rsp: got %h want %h", {rs, rw, rd}, {2'b00, 1'b0, 32'hA1B2C3D4}); end
    n_chk++;
    if (last_araddr !== 32'h0) begin n_fail++; $display("FAIL rd0_araddr: got %h want 0", last_araddr); end
  endtask

  task automatic test_skewed;
    logic [31:0] rd, d; logic [1:0] rs; bit rw, pi, ok; int lat, un, s0, sb0, b0;
    d = $urandom; aw_lat = 4; w_lat = 1; b_resp_k = 2'b01;
    s0 = skew_ok; sb0 = skew_bad; b0 = b_hs;
    do_cmd(1, 32'h4, d, 4'hF, 0, rd, rs, rw, lat, un, pi, ok);
    ref_wr(32'h4, d, 4'hF);
    aw_lat = 0; w_lat = 0; b_resp_k = 0;
    n_chk++;
    if (skew_ok - s0 !== 3 || skew_bad !== sb0) begin
      n_fail++; $display("FAIL skew_window: got ok %0d bad %0d want 3 0", skew_ok - s0, skew_bad - sb0);
    end
    n_chk++;
    if (b_hs - b0 !== 1) begin n_fail++; $display("FAIL skew_b_count: got %0d want 1", b_hs - b0); end
    n_chk++;
    if (!ok || lat !== 8 || rs !== 2'b01) begin n_fail++; $display("FAIL skew_rsp: got lat %0d resp %b want 8 01", lat, rs); end
  endtask

  task automatic test_backpressure;
    logic [31:0] rd; logic [1:0] rs; bit rw, pi, ok; int lat, un;
    r_resp_k = 2'b10;
    do_cmd(0, 32'h4, 32'h0, 4'h0, 5, rd, rs, rw, lat, un, pi, ok);
    r_resp_k = 0;
    n_chk++;
    if (!ok || un !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes want 0", un); end
    n_chk++;
    if ({rs, rd} !== {2'b10, ref_rd(32'h4)}) begin n_fail++; $display("FAIL bp_rsp: got %h want %h", {rs, rd}, {2'b10, ref_rd(32'h4)}); end
    n_chk++;
    if (!pi) begin n_fail++; $display("FAIL bp_release: got busy want idle"); end
  endtask

  task automatic test_wstrb_zero;
    logic [31:0] rd; logic [1:0] rs; bit rw, pi, ok; int lat, un, w0;
    w0 = w_hs;
    do_cmd(1, 32'h0, 32'h55AA55AA, 4'h0, 0, rd, rs, rw, lat, un, pi, ok);
    n_chk++;
    if (!ok || rs !== 2'b00 || w_hs - w0 !== 1) begin n_fail++; $display("FAIL strb0_write: got resp %b w %0d want 00 1", rs, w_hs - w0); end
    do_cmd(0, 32'h0, 32'h0, 4'h0, 0, rd, rs, rw, lat, un, pi, ok);
    n_chk++;
    if (rd !== ref_rd(32'h0)) begin n_fail++; $display("FAIL strb0_read: got %h want %h", rd, ref_rd(32'h0)); end
  endtask

  task automatic test_reset_mid_write;
    logic [31:0] rd; logic [1:0] rs; bit rw, pi, ok; int lat, un, bad, aw0;
    aw_blk = 1; w_blk = 1; aw0 = aw_hs;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h8; cmd_wdata = 32'hDEADBEEF; cmd_wstrb = 4'hF;
    @(negedge ACLK);
    cmd_valid = 0;
    @(negedge ACLK);
    n_chk++;
    if (AWVALID !== 1'b1) begin n_fail++; $display("FAIL rst_pre: got AWVALID %b want 1", AWVALID); end
    #2 ARESETn = 0;
    #1;
    n_chk++;
    if ({AWVALID, WVALID} !== 2'b00) begin n_fail++; $display("FAIL rst_async: got %b want 00", {AWVALID, WVALID}); end
    @(negedge ACLK); @(negedge ACLK);
    ARESETn = 1; aw_blk = 0; w_blk = 0; bad = 0;
    repeat (10) begin @(negedge ACLK); if (rsp_valid) bad++; end
    n_chk++;
    if (bad !== 0 || aw_hs !== aw0) begin n_fail++; $display("FAIL rst_no_rsp: got %0d rsp cycles %0d aw want 0 0", bad, aw_hs - aw0); end
    do_cmd(0, 32'h8, 32'h0, 4'h0, 0, rd, rs, rw, lat, un, pi, ok);
    n_chk++;
    if (!ok || {rs, rd} !== {2'b00, ref_rd(32'h8)}) begin n_fail++; $display("FAIL rst_next_read: got %h want %h", {rs, rd}, {2'b00, ref_rd(32'h8)}); end
  endtask

  task automatic test_random;
    logic [31:0] rd, a, d, exp_d; logic [3:0] s; logic [1:0] rs, er; bit wr, rw, pi, ok; int lat, un;
    for (int t = 0; t < 24; t++) begin
      wr = $urandom_range(0, 1); a = 32'($urandom_range(0, 7) * 4); d = $urandom; s = 4'($urandom_range(0, 15));
      aw_lat = $urandom_range(0, 3); w_lat = $urandom_range(0, 3); ar_lat = $urandom_range(0, 3);
      er = 2'($urandom_range(0, 3));
      if (wr) b_resp_k = er; else r_resp_k = er;
      if (wr) ref_wr(a, d, s);
      exp_d = wr ? 32'h0 : ref_rd(a);
      do_cmd(wr, a, d, s, $urandom_range(0, 3), rd, rs, rw, lat, un, pi, ok);
      n_chk++;
      if (!ok || {rs, rw, rd} !== {er, wr, exp_d}) begin
        n_fail++; $display("FAIL rand_%0d: got %h want %h", t, {rs, rw, rd}, {er, wr, exp_d});
      end
      n_chk++;
      if (un !== 0 || !pi) begin n_fail++; $display("FAIL rand_hold_%0d: got changes %0d idle %b want 0 1", t, un, pi); end
    end
    aw_lat = 0; w_lat = 0; ar_lat = 0; b_resp_k = 0; r_resp_k = 0;
  endtask

`ifdef AXIL_MASTER_TIMEOUT_EN
  task automatic test_timeout;
    logic [31:0] rd; logic [1:0] rs; bit rw, pi, ok; int lat, un;
    ar_blk = 1; mon_en = 0;
    do_cmd(0, 32'h0, 32'h0, 4'h0, 0, rd, rs, rw, lat, un, pi, ok);
    n_chk++;
    if (!ok || lat !== 9 || {rs, rd} !== {2'b10, 32'h0}) begin n_fail++; $display("FAIL timeout_rsp: got lat %0d %h want 9 %h", lat, {rs, rd}, {2'b10, 32'h0}); end
    n_chk++;
    if (ARVALID !== 1'b0) begin n_fail++; $display("FAIL timeout_arvalid: got %b want 0", ARVALID); end
    ar_blk = 0;
    repeat (2) @(negedge ACLK);
    mon_en = 1;
  endtask
`endif

  task automatic test_protocol;
    n_chk++;
    if (proto_err !== 0) begin n_fail++; $display("FAIL axi_protocol: got %0d violations want 0", proto_err); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_write_zero_wait;
    test_read_back;
    test_skewed;
    test_backpressure;
    test_wstrb_zero;
    test_reset_mid_write;
    test_random;
`ifdef AXIL_MASTER_TIMEOUT_EN
    test_timeout;
`endif
    test_protocol;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
